// File: rtl/game_controller_gen_if.sv
// Event, player and display bundle between the game controller and its front end/datapath.
// master = front end driving events; slave = the controller.
interface game_controller_gen_if #(
   parameter int NUM_MODES    = 3,
   parameter int SCORE_DIGITS = 2,
   parameter int PID_W        = 3,
   parameter int IDX_W        = 3,
   parameter int MISS_W       = 4
);
   localparam int MODE_W  = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1;
   localparam int SCORE_W = 4 * SCORE_DIGITS;

   logic               pwdPls;
   logic               logOn;
   logic               startPls;
   logic               loadPls;
   logic               isCorrect;
   logic               isWrong;
   logic               timeOut;
   logic [PID_W-1:0]   pIDin;
   logic               isGuestIn;
   logic [IDX_W-1:0]   indIn1;
   logic [IDX_W-1:0]   indIn2;

   logic [2:0]         controlSig;
   logic               logOut;
   logic [PID_W-1:0]   pIDout;
   logic               isGuestOut;
   logic [SCORE_W-1:0] scoreBcd;
   logic [MISS_W-1:0]  missCnt;
   logic [MODE_W-1:0]  lettNum;
   logic [3:0]         modeDisp;
   logic               scramPls;
   logic               flipPls;
   logic [IDX_W-1:0]   indOut1;
   logic [IDX_W-1:0]   indOut2;
   logic               timerEn;
   logic               timerReconfig;
   logic [SCORE_W-1:0] topScoreBcd;
   logic [PID_W-1:0]   topPid;
   logic [MODE_W-1:0]  topMode;

   modport master (
      output pwdPls, logOn, startPls, loadPls, isCorrect, isWrong, timeOut,
      output pIDin, isGuestIn, indIn1, indIn2,
      input  controlSig, logOut, pIDout, isGuestOut, scoreBcd, missCnt, lettNum, modeDisp,
      input  scramPls, flipPls, indOut1, indOut2, timerEn, timerReconfig,
      input  topScoreBcd, topPid, topMode
   );

   modport slave (
      input  pwdPls, logOn, startPls, loadPls, isCorrect, isWrong, timeOut,
      input  pIDin, isGuestIn, indIn1, indIn2,
      output controlSig, logOut, pIDout, isGuestOut, scoreBcd, missCnt, lettNum, modeDisp,
      output scramPls, flipPls, indOut1, indOut2, timerEn, timerReconfig,
      output topScoreBcd, topPid, topMode
   );
endinterface

// File: rtl/game_controller_gen.sv
// Letter-scramble game controller: login, mode setup, timed play, score record and
// per-mode top-score browsing. Every output is registered.
//
// state      | meaning
// S_INIT     | idle/login screen, clears mode, score and misses
// S_SETUP    | mode select; load cycles modes, wraps into top-score browsing
// S_GAME     | timed play, counts correct/wrong answers
// S_RECORD   | one cycle: latch player, update top-score table
// S_GAMEOVER | show final score until start
// S_LOGOUT   | one-cycle logout pulse
// S_TOPSCORE | browse the top-score table by mode
module game_controller_gen #(
   parameter int NUM_MODES    = 3,
   parameter int SCORE_DIGITS = 2,
   parameter int PID_W        = 3,
   parameter int IDX_W        = 3,
   parameter int MAX_MISSES   = 0,
   parameter int MISS_W       = 4
) (
   input logic                  clk,
   input logic                  rst,
   game_controller_gen_if.slave bus
);
   localparam int MODE_W  = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1;
   localparam int SCORE_W = 4 * SCORE_DIGITS;
   localparam logic [SCORE_W-1:0] SCORE_MAX  = {SCORE_DIGITS{4'h9}};
   localparam logic [MODE_W-1:0]  MODE_LAST  = MODE_W'(NUM_MODES - 1);
   localparam logic [MISS_W-1:0]  MISS_LIMIT = MISS_W'(MAX_MISSES);

   localparam logic [2:0] CS_INIT  = 3'd0;
   localparam logic [2:0] CS_SETUP = 3'd1;
   localparam logic [2:0] CS_GAME  = 3'd2;
   localparam logic [2:0] CS_REC   = 3'd3;
   localparam logic [2:0] CS_TOP   = 3'd4;

   typedef enum logic [2:0] {
      S_INIT, S_SETUP, S_GAME, S_RECORD, S_GAMEOVER, S_LOGOUT, S_TOPSCORE
   } state_t;

   state_t             r_state;
   logic [MODE_W-1:0]  r_mode;
   logic [MODE_W-1:0]  r_view_idx;
   logic [2:0]         r_control_sig;
   logic               r_log_out;
   logic [PID_W-1:0]   r_pid_out;
   logic               r_guest_out;
   logic [SCORE_W-1:0] r_score;
   logic [MISS_W-1:0]  r_miss;
   logic [MODE_W-1:0]  r_lett_num;
   logic [3:0]         r_mode_disp;
   logic               r_scram_pls;
   logic               r_flip_pls;
   logic [IDX_W-1:0]   r_ind_out1;
   logic [IDX_W-1:0]   r_ind_out2;
   logic               r_timer_en;
   logic               r_timer_reconfig;
   logic [SCORE_W-1:0] r_top_score_out;
   logic [PID_W-1:0]   r_top_pid_out;
   logic [MODE_W-1:0]  r_top_mode;
   logic [SCORE_W-1:0] r_tbl_score [NUM_MODES];
   logic [PID_W-1:0]   r_tbl_pid   [NUM_MODES];

   logic [SCORE_W-1:0] w_score_inc;
   logic [MISS_W-1:0]  w_miss_inc;
   logic               w_strike;
   logic               w_new_top;
   logic [3:0]         w_mode_disp;

   function automatic logic [SCORE_W-1:0] bcd_inc(input logic [SCORE_W-1:0] v);
      logic [SCORE_W-1:0] res;
      logic               carry;
      res   = v;
      carry = 1'b1;
      for (int i = 0; i < SCORE_DIGITS; i++) begin
         if (carry) begin
            if (v[4*i +: 4] == 4'd9) begin
               res[4*i +: 4] = 4'd0;
            end else begin
               res[4*i +: 4] = v[4*i +: 4] + 4'd1;
               carry         = 1'b0;
            end
         end
      end
      return res;
   endfunction

   // BCD digits compare correctly as a plain unsigned vector.
   assign w_score_inc = (r_score == SCORE_MAX) ? r_score : bcd_inc(r_score);
   assign w_miss_inc  = (&r_miss) ? r_miss : r_miss + MISS_W'(1);
   assign w_strike    = (MAX_MISSES > 0) && (w_miss_inc == MISS_LIMIT);
   assign w_new_top   = !bus.isGuestIn && (r_score > r_tbl_score[r_mode]);
   assign w_mode_disp = 4'(r_mode) + 4'd4;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state          <= S_INIT;
         r_mode           <= '0;
         r_view_idx       <= '0;
         r_control_sig    <= CS_INIT;
         r_log_out        <= 1'b0;
         r_pid_out        <= '0;
         r_guest_out      <= 1'b0;
         r_score          <= '0;
         r_miss           <= '0;
         r_lett_num       <= '0;
         r_mode_disp      <= '0;
         r_scram_pls      <= 1'b0;
         r_flip_pls       <= 1'b0;
         r_ind_out1       <= '0;
         r_ind_out2       <= '0;
         r_timer_en       <= 1'b0;
         r_timer_reconfig <= 1'b1;
         r_top_score_out  <= '0;
         r_top_pid_out    <= '0;
         r_top_mode       <= '0;
         for (int i = 0; i < NUM_MODES; i++) begin
            r_tbl_score[i] <= '0;
            r_tbl_pid[i]   <= '0;
         end
      end else begin
         r_log_out   <= 1'b0;
         r_scram_pls <= 1'b0;
         r_flip_pls  <= 1'b0;
         case (r_state)
            S_INIT: begin
               r_control_sig    <= CS_INIT;
               r_timer_en       <= 1'b0;
               r_timer_reconfig <= 1'b1;
               r_mode           <= '0;
               r_score          <= '0;
               r_miss           <= '0;
               if (bus.logOn) begin
                  r_state          <= S_SETUP;
                  r_control_sig    <= CS_SETUP;
                  r_timer_reconfig <= 1'b0;
                  r_mode_disp      <= 4'd4;
               end
            end
            S_SETUP: begin
               r_control_sig    <= CS_SETUP;
               r_timer_reconfig <= 1'b0;
               r_mode_disp      <= w_mode_disp;
               if (bus.pwdPls) begin
                  r_state   <= S_LOGOUT;
                  r_log_out <= 1'b1;
               end else if (bus.loadPls) begin
                  if (r_mode < MODE_LAST) begin
                     r_mode      <= r_mode + MODE_W'(1);
                     r_mode_disp <= w_mode_disp + 4'd1;
                  end else begin
                     r_mode          <= '0;
                     r_view_idx      <= '0;
                     r_mode_disp     <= 4'd4;
                     r_state         <= S_TOPSCORE;
                     r_control_sig   <= CS_TOP;
                     r_top_mode      <= '0;
                     r_top_score_out <= r_tbl_score[0];
                     r_top_pid_out   <= r_tbl_pid[0];
                  end
               end else if (bus.startPls) begin
                  r_lett_num    <= r_mode;
                  r_timer_en    <= 1'b1;
                  r_state       <= S_GAME;
                  r_control_sig <= CS_GAME;
               end
            end
            S_GAME: begin
               r_control_sig <= CS_GAME;
               r_scram_pls   <= bus.startPls;
               r_flip_pls    <= bus.loadPls;
               r_ind_out1    <= bus.indIn1;
               r_ind_out2    <= bus.indIn2;
               r_lett_num    <= r_mode;
               if (bus.pwdPls) begin
                  r_timer_en       <= 1'b0;
                  r_timer_reconfig <= 1'b1;
                  r_state          <= S_INIT;
                  r_control_sig    <= CS_INIT;
               end else if (bus.timeOut) begin
                  r_timer_en    <= 1'b0;
                  r_state       <= S_RECORD;
                  r_control_sig <= CS_REC;
               end else if (bus.isCorrect) begin
                  r_score <= w_score_inc;
               end else if (bus.isWrong) begin
                  r_miss <= w_miss_inc;
                  if (w_strike) begin
                     r_timer_en    <= 1'b0;
                     r_state       <= S_RECORD;
                     r_control_sig <= CS_REC;
                  end
               end
            end
            S_RECORD: begin
               r_control_sig <= CS_REC;
               r_pid_out     <= bus.pIDin;
               r_guest_out   <= bus.isGuestIn;
               if (w_new_top) begin
                  r_tbl_score[r_mode] <= r_score;
                  r_tbl_pid[r_mode]   <= bus.pIDin;
               end
               r_state <= S_GAMEOVER;
            end
            S_GAMEOVER: begin
               r_control_sig <= CS_REC;
               if (bus.startPls) begin
                  r_state          <= S_INIT;
                  r_control_sig    <= CS_INIT;
                  r_timer_reconfig <= 1'b1;
               end
            end
            S_LOGOUT: begin
               r_state          <= S_INIT;
               r_control_sig    <= CS_INIT;
               r_timer_reconfig <= 1'b1;
            end
            S_TOPSCORE: begin
               r_control_sig   <= CS_TOP;
               r_top_mode      <= r_view_idx;
               r_top_score_out <= r_tbl_score[r_view_idx];
               r_top_pid_out   <= r_tbl_pid[r_view_idx];
               if (bus.loadPls) begin
                  r_state          <= S_INIT;
                  r_control_sig    <= CS_INIT;
                  r_timer_reconfig <= 1'b1;
               end else if (bus.startPls) begin
                  r_view_idx <= (r_view_idx == MODE_LAST) ? '0 : r_view_idx + MODE_W'(1);
               end
            end
            default: begin
               r_state          <= S_INIT;
               r_control_sig    <= CS_INIT;
               r_timer_en       <= 1'b0;
               r_timer_reconfig <= 1'b1;
            end
         endcase
      end
   end

   assign bus.controlSig    = r_control_sig;
   assign bus.logOut        = r_log_out;
   assign bus.pIDout        = r_pid_out;
   assign bus.isGuestOut    = r_guest_out;
   assign bus.scoreBcd      = r_score;
   assign bus.missCnt       = r_miss;
   assign bus.lettNum       = r_lett_num;
   assign bus.modeDisp      = r_mode_disp;
   assign bus.scramPls      = r_scram_pls;
   assign bus.flipPls       = r_flip_pls;
   assign bus.indOut1       = r_ind_out1;
   assign bus.indOut2       = r_ind_out2;
   assign bus.timerEn       = r_timer_en;
   assign bus.timerReconfig = r_timer_reconfig;
   assign bus.topScoreBcd   = r_top_score_out;
   assign bus.topPid        = r_top_pid_out;
   assign bus.topMode       = r_top_mode;
endmodule
